// File: rtl/wshb_arb_pkg.sv
// Shared types for the SDRAM Wishbone arbiter: requester count, FSM state
// encoding and a saturating counter helper.
package wshb_arb_pkg;

    localparam int ARB_NREQ = 2;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_GNT0   = 3'd1,
        ARB_GNT1   = 3'd2,
        ARB_ABORT0 = 3'd3,
        ARB_ABORT1 = 3'd4
    } arb_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle. A transfer completes in any cycle where cyc & stb
// are high and the slave answers with exactly one of ack/err/rty.
interface wshb_if #(
    parameter int DATA_BYTES = 1,
    parameter int ADDR_WIDTH = 32
) ();

    logic                      cyc;
    logic                      stb;
    logic                      we;
    logic [ADDR_WIDTH-1:0]     adr;
    logic [8*DATA_BYTES-1:0]   dat_ms;
    logic [8*DATA_BYTES-1:0]   dat_sm;
    logic [DATA_BYTES-1:0]     sel;
    logic [2:0]                cti;
    logic [1:0]                bte;
    logic                      ack;
    logic                      err;
    logic                      rty;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output dat_sm, ack, err, rty
    );

endinterface

// File: rtl/wshb_watchdog.sv
// Stall watchdog: counts consecutive cycles in which the owner strobes and the
// slave stays silent, and flags the cycle that reaches the limit.
module wshb_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic run,
    input  logic restart,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Expiry is qualified by run, so a response arriving in the limit cycle
    // still wins over the abort.
    assign expired = run && (count == LIMIT);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            count <= '0;
        end else if (restart || !run) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/wshb_sdram_arbiter.sv
// Round-robin Wishbone arbiter sharing the SDRAM port between the VGA reader
// (requester 0) and a frame writer (requester 1), with a stall watchdog.
module wshb_sdram_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    wshb_if.slave               wshb_ifs0,
    wshb_if.slave               wshb_ifs1,
    wshb_if.master              wshb_ifm,
    output logic [ARB_NREQ-1:0] grant,
    output logic [7:0]          abort_cnt,
    output arb_state_t          arb_state
);

    arb_state_t state;
    arb_state_t state_nx;
    logic       last;
    logic       owner_stb;
    logic       slv_resp;
    logic       wd_run;
    logic       wd_expired;
    logic       state_chg;

    assign slv_resp  = wshb_ifm.ack | wshb_ifm.err | wshb_ifm.rty;
    assign wd_run    = owner_stb & ~slv_resp;
    assign state_chg = (state_nx != state);
    assign arb_state = state;
    assign grant     = {state == ARB_GNT1, state == ARB_GNT0};

    always_comb begin
        owner_stb = 1'b0;
        case (state)
            ARB_GNT0: owner_stb = wshb_ifs0.stb;
            ARB_GNT1: owner_stb = wshb_ifs1.stb;
            default:  owner_stb = 1'b0;
        endcase
    end

    wshb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .run       (wd_run),
        .restart   (state_chg),
        .expired   (wd_expired)
    );

    // An owner releasing cyc takes precedence over a watchdog expiry.
    always_comb begin
        state_nx = state;
        case (state)
            ARB_IDLE: begin
                if (wshb_ifs0.cyc && wshb_ifs1.cyc) begin
                    state_nx = last ? ARB_GNT0 : ARB_GNT1;
                end else if (wshb_ifs0.cyc) begin
                    state_nx = ARB_GNT0;
                end else if (wshb_ifs1.cyc) begin
                    state_nx = ARB_GNT1;
                end
            end
            ARB_GNT0: begin
                if (!wshb_ifs0.cyc) begin
                    state_nx = wshb_ifs1.cyc ? ARB_GNT1 : ARB_IDLE;
                end else if (wd_expired) begin
                    state_nx = ARB_ABORT0;
                end
            end
            ARB_GNT1: begin
                if (!wshb_ifs1.cyc) begin
                    state_nx = wshb_ifs0.cyc ? ARB_GNT0 : ARB_IDLE;
                end else if (wd_expired) begin
                    state_nx = ARB_ABORT1;
                end
            end
            ARB_ABORT0: state_nx = wshb_ifs1.cyc ? ARB_GNT1 : ARB_IDLE;
            ARB_ABORT1: state_nx = wshb_ifs0.cyc ? ARB_GNT0 : ARB_IDLE;
            default:    state_nx = ARB_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ARB_IDLE;
            last      <= 1'b1;
            abort_cnt <= 8'd0;
        end else begin
            state <= state_nx;
            if (state_nx == ARB_GNT0) begin
                last <= 1'b0;
            end else if (state_nx == ARB_GNT1) begin
                last <= 1'b1;
            end
            if (state_chg && (state_nx == ARB_ABORT0 || state_nx == ARB_ABORT1)) begin
                abort_cnt <= sat_inc8(abort_cnt);
            end
        end
    end

    // Forward path: the registered owner drives the slave; idle and abort
    // cycles present an all-zero bus so the slave never sees a half transfer.
    always_comb begin
        wshb_ifm.cyc    = 1'b0;
        wshb_ifm.stb    = 1'b0;
        wshb_ifm.we     = 1'b0;
        wshb_ifm.adr    = '0;
        wshb_ifm.dat_ms = '0;
        wshb_ifm.sel    = '0;
        wshb_ifm.cti    = 3'b000;
        wshb_ifm.bte    = 2'b00;
        case (state)
            ARB_GNT0: begin
                wshb_ifm.cyc    = wshb_ifs0.cyc;
                wshb_ifm.stb    = wshb_ifs0.stb;
                wshb_ifm.we     = wshb_ifs0.we;
                wshb_ifm.adr    = wshb_ifs0.adr;
                wshb_ifm.dat_ms = wshb_ifs0.dat_ms;
                wshb_ifm.sel    = wshb_ifs0.sel;
                wshb_ifm.cti    = wshb_ifs0.cti;
                wshb_ifm.bte    = wshb_ifs0.bte;
            end
            ARB_GNT1: begin
                wshb_ifm.cyc    = wshb_ifs1.cyc;
                wshb_ifm.stb    = wshb_ifs1.stb;
                wshb_ifm.we     = wshb_ifs1.we;
                wshb_ifm.adr    = wshb_ifs1.adr;
                wshb_ifm.dat_ms = wshb_ifs1.dat_ms;
                wshb_ifm.sel    = wshb_ifs1.sel;
                wshb_ifm.cti    = wshb_ifs1.cti;
                wshb_ifm.bte    = wshb_ifs1.bte;
            end
            default: ;
        endcase
    end

    // Return path: read data is broadcast, terminations reach the owner only.
    assign wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
    assign wshb_ifs1.dat_sm = wshb_ifm.dat_sm;
    assign wshb_ifs0.ack    = (state == ARB_GNT0) & wshb_ifm.ack;
    assign wshb_ifs1.ack    = (state == ARB_GNT1) & wshb_ifm.ack;
    assign wshb_ifs0.err    = ((state == ARB_GNT0) & wshb_ifm.err) | (state == ARB_ABORT0);
    assign wshb_ifs1.err    = ((state == ARB_GNT1) & wshb_ifm.err) | (state == ARB_ABORT1);
    assign wshb_ifs0.rty    = (state == ARB_GNT0) & wshb_ifm.rty;
    assign wshb_ifs1.rty    = (state == ARB_GNT1) & wshb_ifm.rty;

endmodule

// File: tb/tb_wshb_sdram_arbiter.sv
// Directed bench for wshb_sdram_arbiter: a bus-ownership model is compared
// against the DUT on every negedge, plus hand-computed literal checks.
module tb_wshb_sdram_arbiter;
    import wshb_arb_pkg::*;

    localparam int TO = 8;

    // ---------------- clock / reset ----------------
    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // ---------------- DUT ----------------
    wshb_if #(.DATA_BYTES(4)) s0 ();
    wshb_if #(.DATA_BYTES(4)) s1 ();
    wshb_if #(.DATA_BYTES(4)) mi ();

    logic [1:0] grant;
    logic [7:0] abort_cnt;
    arb_state_t arb_state;

    wshb_sdram_arbiter #(.TIMEOUT(TO)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wshb_ifs0 (s0),
        .wshb_ifs1 (s1),
        .wshb_ifm  (mi),
        .grant     (grant),
        .abort_cnt (abort_cnt),
        .arb_state (arb_state)
    );

    // ---------------- requester and slave stimulus ----------------
    logic [1:0]  rq_cyc = 2'b00;
    logic [1:0]  rq_stb = 2'b00;
    logic [1:0]  rq_we  = 2'b10;
    logic [31:0] rq_adr [2] = '{32'h0000_1000, 32'h0002_2000};
    logic [31:0] rq_dat [2] = '{32'ha0a0_0001, 32'hb1b1_0002};
    logic [3:0]  rq_sel [2] = '{4'hf, 4'h3};
    logic [2:0]  rq_cti [2] = '{3'b010, 3'b000};
    logic [1:0]  rq_bte [2] = '{2'b00, 2'b01};

    assign s0.cyc = rq_cyc[0];     assign s1.cyc = rq_cyc[1];
    assign s0.stb = rq_stb[0];     assign s1.stb = rq_stb[1];
    assign s0.we  = rq_we[0];      assign s1.we  = rq_we[1];
    assign s0.adr = rq_adr[0];     assign s1.adr = rq_adr[1];
    assign s0.dat_ms = rq_dat[0];  assign s1.dat_ms = rq_dat[1];
    assign s0.sel = rq_sel[0];     assign s1.sel = rq_sel[1];
    assign s0.cti = rq_cti[0];     assign s1.cti = rq_cti[1];
    assign s0.bte = rq_bte[0];     assign s1.bte = rq_bte[1];

    logic        auto_ack = 1'b0;
    logic        man_ack  = 1'b0;
    logic        man_err  = 1'b0;
    logic        man_rty  = 1'b0;
    logic [31:0] sl_dat   = 32'h5a5a_0000;

    assign mi.ack    = man_ack | (auto_ack & mi.cyc & mi.stb);
    assign mi.err    = man_err;
    assign mi.rty    = man_rty;
    assign mi.dat_sm = sl_dat;

    always @(posedge sys_clk) sl_dat <= sl_dat + 32'h0001_0003;

    // ---------------- scoreboard bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: -1 none, else requester index; abort_id: requester being aborted.
    typedef struct {
        int owner;
        int abort_id;
        int last;
        int stall;
        int aborts;
    } mst_t;

    mst_t m = '{owner: -1, abort_id: -1, last: 1, stall: 0, aborts: 0};

    function automatic logic model_resp(input mst_t s);
        logic cs;
        cs = (s.owner >= 0) && rq_cyc[s.owner] && rq_stb[s.owner];
        return man_ack | man_err | man_rty | (auto_ack & cs);
    endfunction

    function automatic mst_t model_next(input mst_t s, input logic resp);
        mst_t n;
        int x;
        n = s;
        if (s.abort_id >= 0) begin
            x = 1 - s.abort_id;
            n.abort_id = -1;
            n.owner = rq_cyc[x] ? x : -1;
        end else if (s.owner >= 0) begin
            x = s.owner;
            if (!rq_cyc[x]) begin
                n.owner = rq_cyc[1 - x] ? 1 - x : -1;
            end else if (rq_stb[x] && !resp) begin
                n.stall = s.stall + 1;
                if (n.stall == TO) begin
                    n.owner = -1;
                    n.abort_id = x;
                    if (n.aborts < 255) n.aborts++;
                end
            end else begin
                n.stall = 0;
            end
        end else begin
            if (rq_cyc[0] && rq_cyc[1]) n.owner = 1 - s.last;
            else if (rq_cyc[0])          n.owner = 0;
            else if (rq_cyc[1])          n.owner = 1;
        end
        if (n.owner != s.owner || n.abort_id != s.abort_id) n.stall = 0;
        if (n.owner >= 0) n.last = n.owner;
        return n;
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) m <= '{owner: -1, abort_id: -1, last: 1, stall: 0, aborts: 0};
        else            m <= model_next(m, model_resp(m));
    end

    task automatic compare_all();
        int o;
        logic e_cyc, e_stb, e_we, e_bus_ack;
        logic [31:0] e_adr, e_dat;
        logic [3:0] e_sel;
        logic [2:0] e_cti, r0, r1;
        logic [1:0] e_bte, e_grant;
        arb_state_t e_st;
        o = m.owner;
        {e_cyc, e_stb, e_we, e_adr, e_dat, e_sel, e_cti, e_bte} = '0;
        e_grant = 2'b00;
        if (o >= 0) begin
            e_grant = 2'(1 << o);
            e_cyc = rq_cyc[o]; e_stb = rq_stb[o]; e_we = rq_we[o];
            e_adr = rq_adr[o]; e_dat = rq_dat[o]; e_sel = rq_sel[o];
            e_cti = rq_cti[o]; e_bte = rq_bte[o];
        end
        e_bus_ack = man_ack | (auto_ack & e_cyc & e_stb);
        r0 = {(o == 0) & e_bus_ack, ((o == 0) & man_err) | (m.abort_id == 0), (o == 0) & man_rty};
        r1 = {(o == 1) & e_bus_ack, ((o == 1) & man_err) | (m.abort_id == 1), (o == 1) & man_rty};
        if (m.abort_id == 0)      e_st = ARB_ABORT0;
        else if (m.abort_id == 1) e_st = ARB_ABORT1;
        else if (o == 0)          e_st = ARB_GNT0;
        else if (o == 1)          e_st = ARB_GNT1;
        else                      e_st = ARB_IDLE;
        chk("grant", grant, e_grant);
        chk("slv_cyc_stb", {mi.cyc, mi.stb}, {e_cyc, e_stb});
        chk("slv_adr", mi.adr, e_adr);
        chk("slv_dat", mi.dat_ms, e_dat);
        chk("slv_ctl", {mi.we, mi.sel, mi.cti, mi.bte}, {e_we, e_sel, e_cti, e_bte});
        chk("rsp0", {s0.ack, s0.err, s0.rty}, r0);
        chk("rsp1", {s1.ack, s1.err, s1.rty}, r1);
        chk("dat_sm", {s0.dat_sm, s1.dat_sm}, {sl_dat, sl_dat});
        chk("abort_cnt", abort_cnt, 8'(m.aborts));
        chk("state", arb_state, e_st);
    endtask

    always @(negedge sys_clk) if (cmp_en) compare_all();

    // grant owner trace for the fairness test
    logic rec_en = 1'b0;
    logic [1:0] rec_prev = 2'b00;
    int own_q[$];
    always @(negedge sys_clk) begin
        if (rec_en && grant != 2'b00 && grant != rec_prev) own_q.push_back((grant == 2'b10) ? 1 : 0);
        rec_prev <= grant;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic c, input logic s);
        rq_cyc[i] = c;
        rq_stb[i] = s;
    endtask

    // Returns at the negedge of the cycle in which requester i sees ack.
    task automatic wait_ack(input int i, input string name);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge sys_clk);
            seen = (i == 0) ? s0.ack : s1.ack;
            if (!seen) tick();
        end
        chk({name, "_ack_seen"}, seen, 1'b1);
    endtask

    task automatic rr_req(input int i);
        for (int k = 0; k < 3; k++) begin
            set_req(i, 1'b1, 1'b1);
            wait_ack(i, "t3");
            tick();
            set_req(i, 1'b0, 1'b0);
            tick();
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int acks0, acks1, c;
        logic seen;
        int rr_exp [4] = '{0, 1, 0, 1};

        @(posedge sys_clk);
        #1;
        cmp_en = 1'b1;

        // reset state
        @(negedge sys_clk);
        chk("rst_grant", grant, 2'b00);
        chk("rst_slv_cyc", {mi.cyc, mi.stb}, 2'b00);
        chk("rst_abort_cnt", abort_cnt, 8'd0);
        chk("rst_rsp", {s0.ack, s0.err, s0.rty, s1.ack, s1.err, s1.rty}, 6'd0);
        tick();
        sys_rst_n = 1'b1;

        // 1: single requester, 4-word incrementing burst
        tick();
        auto_ack = 1'b1;
        set_req(0, 1'b1, 1'b1);
        @(negedge sys_clk);
        chk("t1_grant_req_cycle", grant, 2'b00);
        chk("t1_slv_cyc_req_cycle", mi.cyc, 1'b0);
        tick();
        @(negedge sys_clk);
        chk("t1_grant_next", grant, 2'b01);
        chk("t1_cti", mi.cti, 3'b010);
        acks0 = 0;
        acks1 = 0;
        for (int k = 0; k < 20 && acks0 < 4; k++) begin
            if (s0.ack) acks0++;
            if (s1.ack) acks1++;
            if (acks0 < 4) begin
                tick();
                @(negedge sys_clk);
            end
        end
        chk("t1_acks0", acks0, 4);
        chk("t1_acks1", acks1, 0);
        tick();
        set_req(0, 1'b0, 1'b0);
        tick();
        tick();

        // 2: simultaneous first request after reset, handover gap
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        set_req(0, 1'b1, 1'b1);
        set_req(1, 1'b1, 1'b1);
        @(negedge sys_clk);
        chk("t2_grant_req_cycle", grant, 2'b00);
        tick();
        @(negedge sys_clk);
        chk("t2_first_grant", grant, 2'b01);
        chk("t2_ack0", {s0.ack, s1.ack}, 2'b10);
        tick();
        set_req(0, 1'b0, 1'b0);
        @(negedge sys_clk);
        chk("t2_gap_cyc", mi.cyc, 1'b0);
        tick();
        @(negedge sys_clk);
        chk("t2_second_grant", grant, 2'b10);
        chk("t2_cyc_back", mi.cyc, 1'b1);
        chk("t2_ack1", {s0.ack, s1.ack}, 2'b01);
        tick();
        set_req(1, 1'b0, 1'b0);
        tick();
        tick();

        // 3: round-robin with both requesters continuously requesting
        own_q.delete();
        rec_en = 1'b1;
        fork
            rr_req(0);
            rr_req(1);
        join
        rec_en = 1'b0;
        chk("t3_trace_len", own_q.size() >= 4, 1'b1);
        for (int k = 0; k < 4; k++) chk("t3_owner_seq", own_q[k], rr_exp[k]);
        tick();

        // 4: watchdog abort of req1, pending req0 granted next
        auto_ack = 1'b0;
        set_req(1, 1'b1, 1'b1);
        c = 0;
        seen = 1'b0;
        while (!seen && c < 30) begin
            @(negedge sys_clk);
            if (s1.err) begin
                seen = 1'b1;
                chk("t4_abort_slv_cyc", mi.cyc, 1'b0);
                chk("t4_abort_cnt", abort_cnt, 8'd1);
                chk("t4_abort_grant", grant, 2'b00);
            end else begin
                tick();
                c++;
                if (c == 3) set_req(0, 1'b1, 1'b1);
            end
        end
        chk("t4_err_cycle", c, 9);
        tick();
        set_req(1, 1'b0, 1'b0);
        @(negedge sys_clk);
        chk("t4_err_pulse_len", s1.err, 1'b0);
        chk("t4_next_grant", grant, 2'b01);
        tick();
        auto_ack = 1'b1;
        wait_ack(0, "t4");
        tick();
        set_req(0, 1'b0, 1'b0);
        auto_ack = 1'b0;
        tick();

        // 5: response in the last stall cycle cancels the abort
        set_req(1, 1'b1, 1'b1);
        repeat (8) tick();
        man_ack = 1'b1;
        @(negedge sys_clk);
        chk("t5_late_ack", s1.ack, 1'b1);
        tick();
        man_ack = 1'b0;
        set_req(1, 1'b0, 1'b0);
        @(negedge sys_clk);
        chk("t5_no_err", s1.err, 1'b0);
        chk("t5_abort_cnt", abort_cnt, 8'd1);
        tick();
        @(negedge sys_clk);
        chk("t5_no_err_after", s1.err, 1'b0);
        tick();

        // 7: slave err/rty reach the owner only
        set_req(0, 1'b1, 1'b1);
        tick();
        man_rty = 1'b1;
        @(negedge sys_clk);
        chk("t7_rty", {s0.rty, s1.rty}, 2'b10);
        tick();
        man_rty = 1'b0;
        man_err = 1'b1;
        @(negedge sys_clk);
        chk("t7_err", {s0.err, s1.err}, 2'b10);
        tick();
        man_err = 1'b0;
        set_req(0, 1'b0, 1'b0);
        tick();
        tick();

        // 6: reset asserted mid-burst
        auto_ack = 1'b1;
        set_req(0, 1'b1, 1'b1);
        repeat (3) tick();
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("t6_rst_slv_cyc_stb", {mi.cyc, mi.stb}, 2'b00);
        chk("t6_rst_grant", grant, 2'b00);
        set_req(1, 1'b1, 1'b1);
        tick();
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("t6_idle_after_rst", grant, 2'b00);
        tick();
        @(negedge sys_clk);
        chk("t6_first_after_rst", grant, 2'b01);
        tick();
        set_req(0, 1'b0, 1'b0);
        wait_ack(1, "t6");
        tick();
        set_req(1, 1'b0, 1'b0);
        tick();
        tick();

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_tests++;
        n_fail++;
        $display("FAIL global_timeout: got running expected finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
